// File: rtl/prsg_arb_if.sv
// Bus bundle between the prsg_arb controller and its requesters/consumers.
// With PRSG_STEP_CNT_EN defined the bundle also carries the 16-bit step_cnt.
interface prsg_arb_if #(
    parameter int DIV_W = 4
);
    logic             seed_ld;
    logic [4:0]       seed;
    logic [1:0]       req;
    logic [DIV_W-1:0] tick_div;
    logic [1:0]       gnt;
    logic [4:0]       rnd;
    logic             rnd_vld;
    logic             busy;
    logic             lockup_err;
`ifdef PRSG_STEP_CNT_EN
    logic [15:0]      step_cnt;

    modport master (output seed_ld, seed, req, tick_div,
                    input  gnt, rnd, rnd_vld, busy, lockup_err, step_cnt);
    modport slave  (input  seed_ld, seed, req, tick_div,
                    output gnt, rnd, rnd_vld, busy, lockup_err, step_cnt);
`else
    modport master (output seed_ld, seed, req, tick_div,
                    input  gnt, rnd, rnd_vld, busy, lockup_err);
    modport slave  (input  seed_ld, seed, req, tick_div,
                    output gnt, rnd, rnd_vld, busy, lockup_err);
`endif
endinterface

// File: rtl/prsg_arb.sv
// Round-robin burst arbiter and sequencer for a shared 5-bit LFSR (x^5+x^3+1).
// Optional PRSG_STEP_CNT_EN adds a wrapping 16-bit count of delivered words.
module prsg_arb #(
    parameter int BURST_LEN = 8,
    parameter int DIV_W     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    prsg_arb_if.slave  bus,
    output logic       dbg_state
);
    // Handshake: req is level-held by the winner for the whole burst; each
    // rnd_vld strobe marks one new rnd word, no back-pressure from consumers.
    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    localparam logic [7:0] BURST_CNT = 8'(BURST_LEN);

    state_t           state_q, state_d;
    logic [4:0]       lfsr_q, lfsr_d;
    logic [4:0]       rnd_q, rnd_d;
    logic             rnd_vld_q, rnd_vld_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             lockup_q, lockup_d;
    logic             rr_q, rr_d;
    logic [DIV_W-1:0] presc_q, presc_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [4:0]       lfsr_nxt;
    logic             win_idle;
    logic             win_run;
`ifdef PRSG_STEP_CNT_EN
    logic [15:0]      step_q, step_d;
`endif

    assign lfsr_nxt = {lfsr_q[3:0], lfsr_q[2] ^ lfsr_q[4]};
    assign win_run  = gnt_q[1];
    assign win_idle = (bus.req == 2'b11) ? rr_q : bus.req[1];

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        rnd_d     = rnd_q;
        rnd_vld_d = 1'b0;
        gnt_d     = gnt_q;
        busy_d    = busy_q;
        lockup_d  = 1'b0;
        rr_d      = rr_q;
        presc_d   = presc_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
`ifdef PRSG_STEP_CNT_EN
        step_d    = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.seed_ld) begin
                    lfsr_d   = (bus.seed != 5'd0) ? bus.seed : 5'h1F;
                    lockup_d = (bus.seed == 5'd0);
`ifdef PRSG_STEP_CNT_EN
                    step_d   = 16'd0;
`endif
                end else if (bus.req != 2'b00) begin
                    gnt_d   = win_idle ? 2'b10 : 2'b01;
                    busy_d  = 1'b1;
                    presc_d = '0;
                    cnt_d   = 8'd0;
                    div_d   = bus.tick_div;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Abort and burst completion release the grant identically.
                if (!bus.req[win_run] || cnt_q == BURST_CNT) begin
                    gnt_d   = 2'b00;
                    busy_d  = 1'b0;
                    rr_d    = ~win_run;
                    state_d = ST_IDLE;
                end else if (presc_q == div_q) begin
                    presc_d   = '0;
                    lfsr_d    = lfsr_nxt;
                    rnd_d     = lfsr_nxt;
                    rnd_vld_d = 1'b1;
                    cnt_d     = cnt_q + 8'd1;
`ifdef PRSG_STEP_CNT_EN
                    step_d    = step_q + 16'd1;
`endif
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // All-zero is the LFSR's stuck state; never let it persist.
        if (lfsr_q == 5'd0) begin
            lfsr_d   = 5'h1F;
            lockup_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= 5'h1F;
            rnd_q     <= 5'd0;
            rnd_vld_q <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            lockup_q  <= 1'b0;
            rr_q      <= 1'b0;
            presc_q   <= '0;
            div_q     <= '0;
            cnt_q     <= 8'd0;
`ifdef PRSG_STEP_CNT_EN
            step_q    <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            rnd_q     <= rnd_d;
            rnd_vld_q <= rnd_vld_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            lockup_q  <= lockup_d;
            rr_q      <= rr_d;
            presc_q   <= presc_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
`ifdef PRSG_STEP_CNT_EN
            step_q    <= step_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.rnd        = rnd_q;
    assign bus.rnd_vld    = rnd_vld_q;
    assign bus.busy       = busy_q;
    assign bus.lockup_err = lockup_q;
`ifdef PRSG_STEP_CNT_EN
    assign bus.step_cnt   = step_q;
`endif
    assign dbg_state      = logic'(state_q);

endmodule

// File: tb/tb_prsg_arb.sv
// Bench for prsg_arb: randomized noise during bursts checked against a
// sequence-table model of the generator and round-robin arbitration.
module tb_prsg_arb;
    localparam int BURST_LEN = 8;
    localparam int DIV_W     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dbg_state;

    prsg_arb_if #(.DIV_W(DIV_W)) bus ();

    prsg_arb #(.BURST_LEN(BURST_LEN), .DIV_W(DIV_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the 31-word period listed from the reset value, a position in it,
    // the round-robin pointer and the delivered-word count.
    logic [4:0] seq [31];
    int         m_idx;
    logic       m_rr;
    int         m_steps;
    logic [4:0] exp_q [$];

    task automatic build_seq();
        logic [4:0] v;
        v = 5'h1F;
        for (int i = 0; i < 31; i++) begin
            seq[i] = v;
            v = {v[3:0], v[2] ^ v[4]};
        end
    endtask

    task automatic apply_reset();
        rst_n        = 1'b0;
        bus.req      = 2'b00;
        bus.seed_ld  = 1'b0;
        bus.seed     = 5'd0;
        bus.tick_div = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        m_idx   = 0;
        m_rr    = 1'b0;
        m_steps = 0;
    endtask

    task automatic do_burst(input logic [1:0] r, input logic [3:0] div, input int drop, input bit keep);
        logic       win;
        logic [1:0] eg;
        logic [4:0] exp;
        int         nw;
        win = (r == 2'b11) ? m_rr : r[1];
        eg  = win ? 2'b10 : 2'b01;
        nw  = (drop > 0) ? drop : BURST_LEN;
        exp_q.delete();
        for (int i = 0; i < nw; i++) begin
            m_idx = (m_idx + 1) % 31;
            exp_q.push_back(seq[m_idx]);
        end
        bus.req      = r;
        bus.tick_div = div;
        bus.seed_ld  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.gnt !== eg) begin errors++; $display("FAIL grant: gnt=%b want %b", bus.gnt, eg); end
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_run: busy=%b want 1", bus.busy); end
        for (int w = 0; w < nw; w++) begin
            for (int c = 0; c <= int'(div); c++) begin
                bus.tick_div = 4'($urandom_range(0, 15));
                bus.seed_ld  = 1'($urandom_range(0, 1));
                bus.seed     = 5'($urandom);
                if (r != 2'b11) begin
                    if (win) bus.req[0] = 1'($urandom_range(0, 1));
                    else     bus.req[1] = 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                if (c < int'(div)) begin
                    checks++;
                    if (bus.rnd_vld !== 1'b0) begin
                        errors++; $display("FAIL vld_gap: word %0d slot %0d rnd_vld=%b want 0", w, c, bus.rnd_vld);
                    end
                end else begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (bus.rnd_vld !== 1'b1 || bus.rnd !== exp) begin
                        errors++;
                        $display("FAIL word: idx %0d rnd_vld=%b rnd=%h want vld=1 rnd=%h", w, bus.rnd_vld, bus.rnd, exp);
                    end
                end
            end
        end
        if (drop > 0) bus.req = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.rnd_vld !== 1'b0) begin
            errors++;
            $display("FAIL release: gnt=%b busy=%b rnd_vld=%b want 00/0/0", bus.gnt, bus.busy, bus.rnd_vld);
        end
        m_rr    = ~win;
        m_steps = m_steps + nw;
`ifdef PRSG_STEP_CNT_EN
        checks++;
        if (bus.step_cnt !== 16'(m_steps)) begin
            errors++; $display("FAIL step_cnt: got %0d want %0d", bus.step_cnt, m_steps);
        end
`endif
        bus.seed_ld = 1'b0;
        bus.req     = keep ? r : 2'b00;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.rnd_vld !== 1'b0 ||
            bus.rnd !== 5'd0 || bus.lockup_err !== 1'b0 || dbg_state !== 1'b0) begin
            errors++;
            $display("FAIL reset: gnt=%b busy=%b vld=%b rnd=%h lock=%b st=%b want all 0",
                     bus.gnt, bus.busy, bus.rnd_vld, bus.rnd, bus.lockup_err, dbg_state);
        end
`ifdef PRSG_STEP_CNT_EN
        checks++;
        if (bus.step_cnt !== 16'd0) begin errors++; $display("FAIL reset_step: got %0d want 0", bus.step_cnt); end
`endif
    endtask

    task automatic test_basic();
        apply_reset();
        do_burst(2'b01, 4'd0, 0, 1'b0);
    endtask

    task automatic test_alternate();
        apply_reset();
        for (int i = 0; i < 4; i++) do_burst(2'b11, 4'd0, 0, i < 3);
    endtask

    task automatic test_tick_div();
        logic [1:0] r;
        do_burst(2'b10, 4'd3, 0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            r = 2'($urandom_range(1, 3));
            do_burst(r, 4'($urandom_range(0, 3)), 0, 1'b0);
        end
    endtask

    task automatic test_seed(input logic [4:0] s);
        logic [4:0] start;
        start = (s == 5'd0) ? 5'h1F : s;
        bus.seed_ld = 1'b1;
        bus.seed    = s;
        bus.req     = 2'b01;
        @(posedge clk); #1;
        checks++;
        if (bus.lockup_err !== (s == 5'd0) || bus.gnt !== 2'b00 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL seed_load: seed=%h lock=%b gnt=%b busy=%b want lock=%b gnt=00 busy=0",
                     s, bus.lockup_err, bus.gnt, bus.busy, (s == 5'd0));
        end
        for (int i = 0; i < 31; i++) if (seq[i] == start) m_idx = i;
        m_steps     = 0;
        bus.seed_ld = 1'b0;
        bus.req     = 2'b00;
        @(posedge clk); #1;
        checks++;
        if (bus.lockup_err !== 1'b0) begin errors++; $display("FAIL lock_pulse: lock=%b want 0", bus.lockup_err); end
`ifdef PRSG_STEP_CNT_EN
        checks++;
        if (bus.step_cnt !== 16'd0) begin errors++; $display("FAIL seed_step: got %0d want 0", bus.step_cnt); end
`endif
    endtask

    task automatic test_seed_cases();
        test_seed(5'h00);
        do_burst(2'b01, 4'd0, 0, 1'b0);
        test_seed(5'h01);
        do_burst(2'b01, 4'd0, 0, 1'b0);
        test_seed(5'($urandom_range(1, 31)));
        do_burst(2'b10, 4'($urandom_range(0, 2)), 0, 1'b0);
    endtask

    task automatic test_abort();
        apply_reset();
        do_burst(2'b01, 4'd0, 3, 1'b0);
        do_burst(2'b11, 4'd0, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.req      = 2'b01;
        bus.tick_div = '0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.gnt !== 2'b00 || bus.busy !== 1'b0 || bus.rnd_vld !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: gnt=%b busy=%b vld=%b want 00/0/0", bus.gnt, bus.busy, bus.rnd_vld);
        end
        bus.req = 2'b00;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        m_idx   = 0;
        m_rr    = 1'b0;
        m_steps = 0;
        do_burst(2'b01, 4'd0, 0, 1'b0);
    endtask

    initial begin
        build_seq();
        test_reset();
        test_basic();
        test_alternate();
        test_tick_div();
        test_seed_cases();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
